// File: rtl/ha_mul_pkg.sv
// Shared constants, row record and FSM states for the approximate 8x8 multiplier.
// The half-adder front end and the iterative reducer back end both use them.
package ha_mul_pkg;

   localparam int ROWS           = 4;
   localparam int T_W            = 9;
   localparam int B_W            = 7;
   localparam int B_OFFSET       = 2;
   localparam int ROW_SHIFT      = 2;
   localparam int RV_W           = 10;
   localparam int PROD_W_DEFAULT = 16;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   // One compressed half-adder row: sum vector plus its carry vector.
   typedef struct packed {
      logic [T_W-1:0] t;
      logic [B_W-1:0] b;
   } ha_row_t;

endpackage

// File: rtl/ha_row_value.sv
// Collapses one half-adder row pair into its unweighted value.
// The carry bits sit B_OFFSET above the sum bits.
module ha_row_value
   import ha_mul_pkg::*;
(
   input  logic [T_W-1:0]  t,
   input  logic [B_W-1:0]  b,
   output logic [RV_W-1:0] rv
);

   // The largest result is 511 + 508 = 1019, so RV_W bits never overflow.
   assign rv = RV_W'(t) + (RV_W'(b) << B_OFFSET);

endmodule

// File: rtl/ha_array_reducer.sv
// Iterative back end of the approximate multiplier.
// It adds one captured row per cycle into acc and presents the product with a valid/ready handshake.
module ha_array_reducer
   import ha_mul_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [T_W-1:0]    ha_array_0_t,
   input  logic [T_W-1:0]    ha_array_1_t,
   input  logic [T_W-1:0]    ha_array_2_t,
   input  logic [T_W-1:0]    ha_array_3_t,
   input  logic [B_W-1:0]    ha_array_0_b,
   input  logic [B_W-1:0]    ha_array_1_b,
   input  logic [B_W-1:0]    ha_array_2_b,
   input  logic [B_W-1:0]    ha_array_3_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy
);

   localparam int CNT_W = $clog2(ROWS);
   localparam int SH_W  = $clog2(ROW_SHIFT*(ROWS-1)+1);

   state_t                       state;
   ha_row_t [ROWS-1:0]           rows_q;
   ha_row_t [ROWS-1:0]           rows_d;
   logic    [CNT_W-1:0]          row_cnt;
   logic    [PROD_W-1:0]         acc;
   logic    [RV_W-1:0]           rv;
   logic    [SH_W-1:0]           shamt;
   logic    [PROD_W+RV_W-1:0]    contrib_w;

   assign rows_d = {ha_array_3_t, ha_array_3_b, ha_array_2_t, ha_array_2_b,
                    ha_array_1_t, ha_array_1_b, ha_array_0_t, ha_array_0_b};

   // A single row evaluator is time-shared across the rows through the row_cnt mux.
   ha_row_value u_row_value (
      .t  (rows_q[row_cnt].t),
      .b  (rows_q[row_cnt].b),
      .rv (rv)
   );

   assign shamt     = SH_W'(row_cnt) * SH_W'(ROW_SHIFT);
   assign contrib_w = {PROD_W'(0), rv} << shamt;

   // A consumer draining DONE frees the input side in the same cycle.
   assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
   assign product  = acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rows_q    <= '0;
         row_cnt   <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  rows_q  <= rows_d;
                  acc     <= '0;
                  row_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= ACC;
               end
            end
            ACC: begin
               acc <= acc + contrib_w[PROD_W-1:0];
               if (row_cnt == CNT_W'(ROWS-1)) begin
                  row_cnt   <= '0;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  row_cnt <= row_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     rows_q  <= rows_d;
                     acc     <= '0;
                     row_cnt <= '0;
                     busy    <= 1'b1;
                     state   <= ACC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ha_array_reducer.sv
// Self-checking bench for ha_array_reducer: directed vector table, stall, reset and random traffic.
// Expected products come from bit weights or from x*y through a half-adder front-end model.
module tb_ha_array_reducer;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       product;
   logic              busy;
   logic [3:0][8:0]   t_in;
   logic [3:0][6:0]   b_in;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   ha_array_reducer #(.PROD_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_t (t_in[0]),
      .ha_array_1_t (t_in[1]),
      .ha_array_2_t (t_in[2]),
      .ha_array_3_t (t_in[3]),
      .ha_array_0_b (b_in[0]),
      .ha_array_1_b (b_in[1]),
      .ha_array_2_b (b_in[2]),
      .ha_array_3_b (b_in[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   typedef struct {
      logic [3:0][8:0] t;
      logic [3:0][6:0] b;
      logic [15:0]     exp;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference value of a row set, computed from the bit weights alone.
   function automatic logic [15:0] ref_sum(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
      longint s = 0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 9; i++) if (t[k][i]) s += longint'(1) << (2*k + i);
         for (int j = 0; j < 7; j++) if (b[k][j]) s += longint'(1) << (2*k + j + 2);
      end
      return 16'(s % 65536);
   endfunction

   // Half-adder compression of partial-product rows 2k and 2k+1 for x*y.
   task automatic front_end(input logic [7:0] x, input logic [7:0] y,
                            output logic [3:0][8:0] t, output logic [3:0][6:0] b);
      logic [8:0] a, c, cy;
      for (int k = 0; k < 4; k++) begin
         a    = y[2*k]   ? {1'b0, x} : 9'h0;
         c    = y[2*k+1] ? {x, 1'b0} : 9'h0;
         cy   = a & c;
         t[k] = a ^ c;
         b[k] = cy[7:1];
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   initial begin
      int               lat;
      logic [3:0][8:0]  tt;
      logic [3:0][6:0]  bb;
      logic [15:0]      q[$];
      logic [15:0]      pend_exp;
      logic [7:0]       x, y;
      int               sent, recv, cyc;
      logic             fire_in, fire_out;

      for (int i = 0; i < 7; i++) begin
         tbl[i].t = '0;
         tbl[i].b = '0;
      end
      tbl[0].exp = 16'd0;
      tbl[1].t[0] = 9'h001;  tbl[1].exp = 16'd1;
      tbl[2].b[3] = 7'h40;   tbl[2].exp = 16'd16384;
      tbl[3].t = {4{9'h1FF}}; tbl[3].b = {4{7'h7F}}; tbl[3].exp = 16'd21079;
      front_end(8'hFF, 8'hFF, tt, bb);
      tbl[4].t = tt;  tbl[4].b = bb;  tbl[4].exp = 16'd65025;
      tbl[5].t[1] = 9'h100;  tbl[5].exp = 16'd1024;
      tbl[6].b[2] = 7'h01;   tbl[6].exp = 16'd64;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; t_in = '0; b_in = '0;
      step(); step();
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_product", 32'(product), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      step();

      // Directed table: each set accepted from IDLE, 4-cycle latency, drained at once.
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         t_in = tbl[i].t; b_in = tbl[i].b; in_valid = 1'b1;
         #1;
         chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
         step();
         in_valid = 1'b0; t_in = '0; b_in = '0;
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'd1);
         wait_out(lat);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd4);
         chk($sformatf("tbl%0d_product", i), 32'(product), 32'(tbl[i].exp));
         step();
         chk($sformatf("tbl%0d_idle_ready", i), 32'(in_ready), 32'd1);
         chk($sformatf("tbl%0d_out_valid_low", i), 32'(out_valid), 32'd0);
      end

      // Stall in DONE, then a back-to-back accept on the drain cycle.
      out_ready = 1'b0;
      t_in = tbl[3].t; b_in = tbl[3].b; in_valid = 1'b1;
      step();
      t_in = tbl[2].t; b_in = tbl[2].b;
      wait_out(lat);
      chk("stall_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 10; i++) begin
         chk("stall_product", 32'(product), 32'd21079);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      t_in = tbl[1].t; b_in = tbl[1].b; out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0; t_in = '0; b_in = '0;
      chk("b2b_out_valid_low", 32'(out_valid), 32'd0);
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_out(lat);
      chk("b2b_latency", 32'(lat), 32'd4);
      chk("b2b_product", 32'(product), 32'd1);
      step();

      // Reset while two rows have been added.
      t_in = tbl[3].t; b_in = tbl[3].b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_product", 32'(product), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) lat++;
         step();
      end
      chk("abort_never_output", 32'(lat), 32'd0);

      // Random traffic with random stalls; handshakes are evaluated at negedge.
      sent = 0; recv = 0; cyc = 0; pend_exp = '0;
      in_valid = 1'b0; out_ready = 1'b1;
      while (recv < 1000 && cyc < 30000) begin
         @(negedge clk);
         fire_in  = in_valid & in_ready;
         fire_out = out_valid & out_ready;
         if (fire_out) begin
            if (q.size() == 0) chk("rand_unexpected_output", 32'(product), 32'hFFFF_FFFF);
            else chk($sformatf("rand_product_%0d", recv), 32'(product), 32'(q.pop_front()));
            recv++;
         end
         if (fire_in) begin
            q.push_back(pend_exp);
            sent++;
         end
         step();
         cyc++;
         if (fire_in || !in_valid) begin
            if (sent < 1000 && $urandom_range(0, 9) < 8) begin
               if ($urandom_range(0, 1) == 1) begin
                  x = 8'($urandom); y = 8'($urandom);
                  front_end(x, y, tt, bb);
                  pend_exp = 16'(x) * 16'(y);
               end else begin
                  for (int k = 0; k < 4; k++) begin
                     tt[k] = 9'($urandom);
                     bb[k] = 7'($urandom);
                  end
                  pend_exp = ref_sum(tt, bb);
               end
               t_in = tt; b_in = bb; in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0;
      chk("rand_received", 32'(recv), 32'd1000);
      chk("rand_sent", 32'(sent), 32'd1000);
      chk("rand_queue_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
